// File: rtl/gps_pkg.sv
// Shared GPS tracking definitions: C/A code length, the dumped-sum bundle and the
// saturating adder used by every correlator arm.
package gps_pkg;

  localparam int unsigned CA_CHIPS  = 1023;
  localparam int unsigned SUM_W     = 20;

  typedef struct packed {
    logic signed [SUM_W-1:0] ei;
    logic signed [SUM_W-1:0] eq;
    logic signed [SUM_W-1:0] pi;
    logic signed [SUM_W-1:0] pq;
    logic signed [SUM_W-1:0] li;
    logic signed [SUM_W-1:0] lq;
  } corr_sums_t;

  // Adds two values already representable in w bits and clamps to the w-bit signed range.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned       w);
    logic signed [32:0] s;
    logic signed [32:0] max_v;
    logic signed [32:0] min_v;
    s     = {a[31], a} + {b[31], b};
    max_v = (33'sd1 <<< (w - 1)) - 33'sd1;
    min_v = -(33'sd1 <<< (w - 1));
    if (s > max_v) begin
      s = max_v;
    end else if (s < min_v) begin
      s = min_v;
    end
    return s[31:0];
  endfunction

endpackage

// File: rtl/corr_arm.sv
// One correlator arm: wipes a C/A bit off one sample rail and accumulates with saturation.
// sum_o is the accumulator including this cycle's contribution, used for the dump.
module corr_arm
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 4,
  parameter int unsigned ACC_W    = 20
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      en_i,
  input  logic                      code_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]    sum_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [31:0]      smp_ext;
  logic signed [31:0]      contrib;

  always_comb begin
    smp_ext = 32'(sample_i);
    // Code bit 1 maps to -1.
    contrib = code_i ? -smp_ext : smp_ext;
    sum_o   = en_i ? ACC_W'(sat_add(32'(acc_q), contrib, ACC_W)) : acc_q;
    acc_d   = clr_i ? '0 : sum_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/epl_correlator.sv
// Early/punctual/late integrate-and-dump correlator with a ready/valid dump port.
// Sums are dumped on the last chip tick of each epoch; unread dumps are overwritten.
module epl_correlator
  import gps_pkg::*;
#(
  parameter int unsigned SAMPLE_W        = 4,
  parameter int unsigned ACC_W           = 20,
  parameter int unsigned CHIPS_PER_EPOCH = CA_CHIPS,
  parameter int unsigned EPOCH_CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sample_valid,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  input  logic signed [SAMPLE_W-1:0] sample_q,
  input  logic                       code_e,
  input  logic                       code_p,
  input  logic                       code_l,
  input  logic                       chip_tick,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic signed [ACC_W-1:0]    ei,
  output logic signed [ACC_W-1:0]    eq,
  output logic signed [ACC_W-1:0]    pi,
  output logic signed [ACC_W-1:0]    pq,
  output logic signed [ACC_W-1:0]    li,
  output logic signed [ACC_W-1:0]    lq,
  output logic [EPOCH_CNT_W-1:0]     epoch_cnt,
  output logic                       overrun
);

  localparam int unsigned CntW = $clog2(CHIPS_PER_EPOCH + 1);
  localparam logic [CntW-1:0] LastChip = CntW'(CHIPS_PER_EPOCH - 1);

  logic                    armed_q, armed_d;
  logic [CntW-1:0]         chip_cnt_q, chip_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic                    overrun_q, overrun_d;
  logic [EPOCH_CNT_W-1:0]  epoch_cnt_q, epoch_cnt_d;
  logic signed [ACC_W-1:0] dump_q [6];
  logic signed [ACC_W-1:0] sum_w [6];
  logic [5:0]              code_sel;
  logic                    boundary, consume, acc_en, acc_clr;

  // Arm order: EI, EQ, PI, PQ, LI, LQ.
  assign code_sel = {code_l, code_l, code_p, code_p, code_e, code_e};

  always_comb begin
    // start takes priority over a coincident boundary.
    boundary = armed_q & chip_tick & (chip_cnt_q == LastChip) & ~start;
    consume  = out_valid_q & out_ready;
    acc_en   = armed_q & sample_valid;
    acc_clr  = start | boundary;
  end

  for (genvar k = 0; k < 6; k++) begin : g_arm
    corr_arm #(
      .SAMPLE_W(SAMPLE_W),
      .ACC_W   (ACC_W)
    ) u_arm (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (acc_clr),
      .en_i    (acc_en),
      .code_i  (code_sel[k]),
      .sample_i((k % 2 == 0) ? sample_i : sample_q),
      .sum_o   (sum_w[k])
    );
  end

  always_comb begin
    armed_d     = armed_q | start;
    chip_cnt_d  = chip_cnt_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    epoch_cnt_d = epoch_cnt_q;
    if (start) begin
      chip_cnt_d = '0;
    end else if (armed_q && chip_tick) begin
      chip_cnt_d = (chip_cnt_q == LastChip) ? '0 : chip_cnt_q + 1'b1;
    end
    if (boundary) begin
      out_valid_d = 1'b1;
      epoch_cnt_d = epoch_cnt_q + 1'b1;
      if (out_valid_q && !out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    if (start) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q     <= 1'b0;
      chip_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      epoch_cnt_q <= '0;
      for (int k = 0; k < 6; k++) begin
        dump_q[k] <= '0;
      end
    end else begin
      armed_q     <= armed_d;
      chip_cnt_q  <= chip_cnt_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
      epoch_cnt_q <= epoch_cnt_d;
      if (boundary) begin
        for (int k = 0; k < 6; k++) begin
          dump_q[k] <= sum_w[k];
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
  assign epoch_cnt = epoch_cnt_q;
  assign ei        = dump_q[0];
  assign eq        = dump_q[1];
  assign pi        = dump_q[2];
  assign pq        = dump_q[3];
  assign li        = dump_q[4];
  assign lq        = dump_q[5];

endmodule

// File: doc/epl_correlator.md
Name: epl_correlator

Overview:
Integrate-and-dump correlator downstream of the C/A code NCO. It wipes the early, punctual and late C/A code bits off the incoming baseband I/Q samples and accumulates six sums (EI, EQ, PI, PQ, LI, LQ) over one code epoch. At each epoch boundary it dumps the sums to a ready/valid output that feeds the DLL/PLL discriminator stage.

Parameters:
SAMPLE_W, 4, signed two's-complement width of sample_i and sample_q
ACC_W, 20, signed width of each accumulator and each output sum
CHIPS_PER_EPOCH, 1023, number of chip ticks per dump period
EPOCH_CNT_W, 16, width of the epoch sequence counter

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse: clear accumulators and chip counter, arm the correlator
sample_valid  in  1  sample_i and sample_q are valid this cycle
sample_i  in  SAMPLE_W  signed in-phase baseband sample
sample_q  in  SAMPLE_W  signed quadrature baseband sample
code_e  in  1  early C/A bit, time-aligned with the sample
code_p  in  1  punctual C/A bit
code_l  in  1  late C/A bit
chip_tick  in  1  pulse on the last cycle of each punctual chip
out_ready  in  1  downstream accepts the dump
out_valid  out  1  dump registers hold an unread result
ei, eq, pi, pq, li, lq  out  ACC_W each  signed dumped sums
epoch_cnt  out  EPOCH_CNT_W  sequence number of the current dump
overrun  out  1  sticky: a dump overwrote an unread result

Behaviour:
- Reset: all accumulators, dump registers and outputs are 0. Chip counter is 0. armed=0. out_valid=0. overrun=0. epoch_cnt=0.
- Idle (armed=0): samples and chip_tick are ignored.
- start: in the next cycle the accumulators and chip counter are 0 and armed=1. The sample presented in the start cycle is discarded. Dump registers, out_valid and epoch_cnt are unaffected. overrun is cleared. start while armed re-aligns the correlator in the same way.
- Wipe-off: a code bit of 0 maps to +1 and a code bit of 1 maps to -1. Each contribution is ±sample, sign-extended to ACC_W.
- Accumulation: happens only when armed and sample_valid. Each add saturates at +(2^(ACC_W-1)-1) and -2^(ACC_W-1), with no wrap.
- Chip counter: when armed, it increments on each chip_tick. Epoch boundary = chip_tick while the counter is CHIPS_PER_EPOCH-1; on that cycle the counter returns to 0.
- Dump, on the boundary cycle:
  - The dump registers take the accumulator plus that cycle's contribution, if sample_valid.
  - The accumulators clear to 0.
  - out_valid goes to 1 the next cycle.
  - epoch_cnt increments, wrapping modulo 2^EPOCH_CNT_W.
- Latency: the first dumped value is visible 1 cycle after the boundary cycle.
- Handshake:
  - The result is consumed on a cycle with out_valid and out_ready; out_valid then drops next cycle unless a new dump occurs in that same cycle.
  - Dump registers are stable while out_valid=1 and not consumed.
- Overrun: a dump while out_valid=1 and not consumed overwrites the dump registers and sets overrun. A dump in the same cycle as a consume does not set overrun, and out_valid stays 1.
- start and a boundary in the same cycle: start wins and no dump occurs.
- rst mid-epoch: immediate return to the reset state, including armed=0.

Decomposition:
- Shared package gps_pkg holds:
  - the corr_sums_t struct of the six ACC_W sums;
  - the CA_CHIPS=1023 constant;
  - a sat_add function for the saturating adder.
- Sub-module corr_arm (instantiated 6×) does the sign wipe-off and the saturating accumulate/clear for one code/sample pair.

Test Plan:
- CHIPS_PER_EPOCH=4, 2 valid samples per chip, sample_i=+3, sample_q=-2, all codes 0 -> one dump with pi=ei=li=24, pq=eq=lq=-16, epoch_cnt=1.
- Same stimulus with code_l=1 throughout and code_e toggling each chip -> li=-24, lq=+16, ei=0, eq=0.
- ACC_W=6, sample_i=+7, code_p=0, 10 samples per epoch -> pi saturates at +31, with no wrap.
- out_ready=0 across two epochs -> overrun=1, out_valid stays 1, and the data equals the second epoch's sums. Then out_ready=1 for one cycle -> out_valid=0 the next cycle.
- Dump coincident with out_ready=1 while out_valid=1 -> overrun stays 0, out_valid stays 1, new data is presented.
- Assert rst mid-epoch after 5 samples, then start -> all outputs are 0, and the next dump contains only post-start samples. start on the boundary cycle -> no dump and epoch_cnt unchanged.
